// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
//
// Interrupt controller for the single-cycle CPU. Two level interrupt lines are
// edge-detected into pending bits and arbitrated by fixed priority (irq[0]
// highest). Entry and exit are sequenced here:
// - entry pushes the return PC and steers the PC mux to the winning vector;
// - exit pops the stack and steers the PC mux to the popped address.
// The block also owns the shared return-stack strobes and occupancy count.
// CPU call/ret requests pass through it, so the stack is never over- or
// under-flowed.
//
// Build option:
//   NESTING_EN  when defined, an enabled handler can be preempted by a pending
//               source of higher priority than any source in service. When not
//               defined, pending requests wait until the machine is back in
//               idle.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   irq[1:0]    interrupt request lines (level, edge-detected here)
//   ei / di     enable / disable interrupts instruction this cycle
//   reti        return-from-interrupt instruction this cycle
//   cpu_push    CPU call wants to push ret_pc
//   cpu_pop     CPU ret wants to pop
//   ret_pc      address of the next sequential instruction
//   vec0/vec1   handler vectors for irq[0] / irq[1]
//   push/pop    return-stack strobes
//   push_data   data written to the return stack
//   pc_src      PC mux select: 00 sequential/CPU, 01 pc_vec, 10 stack output
//   pc_vec      vector of the source being entered
//   irq_ack     one-cycle acknowledge per source
//   in_service  sources whose handlers are currently active
//   gie         global interrupt enable
//   stack_err   sticky flag: a stack request was refused
// -----------------------------------------------------------------------------
module irq_sequencer #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      irq,
    input  logic            ei,
    input  logic            di,
    input  logic            reti,
    input  logic            cpu_push,
    input  logic            cpu_pop,
    input  logic [PC_W-1:0] ret_pc,
    input  logic [PC_W-1:0] vec0,
    input  logic [PC_W-1:0] vec1,
    output logic            push,
    output logic            pop,
    output logic [PC_W-1:0] push_data,
    output logic [1:0]      pc_src,
    output logic [PC_W-1:0] pc_vec,
    output logic [1:0]      irq_ack,
    output logic [1:0]      in_service,
    output logic            gie,
    output logic            stack_err
);

    localparam int unsigned       DepthW    = $clog2(STACK_DEPTH + 1);
    localparam logic [DepthW-1:0] DepthFull = DepthW'(STACK_DEPTH);
    localparam logic [DepthW-1:0] DepthOne  = DepthW'(1);

    localparam logic [1:0] PcSeq   = 2'b00;
    localparam logic [1:0] PcVec   = 2'b01;
    localparam logic [1:0] PcStack = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StEnter,
        StService,
        StReturn
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [1:0]        irq_prev_q;
    logic [1:0]        pend_q, pend_d;
    logic [1:0]        in_service_q, in_service_d;
    logic              gie_q, gie_d;
    logic              stack_err_q, stack_err_d;
    logic [DepthW-1:0] depth_q, depth_d;
    // Source being entered: 0 -> irq[0], 1 -> irq[1]. Latched when the entry
    // decision is made so a request arriving during ENTER cannot change it.
    logic              win_q, win_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    logic [1:0]        irq_rise;
    logic              fwd_push;
    logic              fwd_pop;
    logic              fwd_err;
    logic [DepthW-1:0] depth_fwd;
    logic              gie_instr;
    logic              preempt;
    logic              pend_win;

    assign irq_rise = irq & ~irq_prev_q;

    // Lowest pending index wins.
    assign pend_win = ~pend_q[0];

    // ei/di as decoded this cycle; di wins when both are present.
    assign gie_instr = di ? 1'b0 : (ei ? 1'b1 : gie_q);

    // CPU call/ret filter. A refused request, or a push and a pop in the same
    // cycle, raises the error flag. In the simultaneous case the pop wins.
    always_comb begin
        fwd_push = 1'b0;
        fwd_pop  = 1'b0;
        fwd_err  = 1'b0;
        if (cpu_pop) begin
            if (depth_q != '0) begin
                fwd_pop = 1'b1;
            end
            if ((depth_q == '0) || cpu_push) begin
                fwd_err = 1'b1;
            end
        end else if (cpu_push) begin
            if (depth_q != DepthFull) begin
                fwd_push = 1'b1;
            end else begin
                fwd_err = 1'b1;
            end
        end
    end

    // Occupancy after this cycle's forwarded CPU traffic. Entry checks this
    // value rather than depth_q: a CPU push in the deciding cycle must not
    // leave ENTER pushing into a full stack.
    assign depth_fwd = depth_q + DepthW'(fwd_push) - DepthW'(fwd_pop);

`ifdef NESTING_EN
    // With two sources, only irq[0] can outrank an active handler, and only
    // when the sole source in service is irq[1].
    assign preempt = gie_q & pend_q[0] & ~in_service_q[0] & in_service_q[1];
`else
    assign preempt = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q | irq_rise;
        in_service_d = in_service_q;
        gie_d        = gie_q;
        stack_err_d  = stack_err_q;
        depth_d      = depth_q;
        win_d        = win_q;

        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        pc_src    = PcSeq;
        pc_vec    = '0;
        irq_ack   = 2'b00;

        unique case (state_q)
            StIdle: begin
                push      = fwd_push;
                pop       = fwd_pop;
                push_data = ret_pc;
                depth_d   = depth_fwd;
                gie_d     = gie_instr;
                // reti with nothing in service is always an error here.
                if (fwd_err || reti) begin
                    stack_err_d = 1'b1;
                end
                if (gie_q && (pend_q != 2'b00) && (depth_fwd < DepthFull)) begin
                    state_d = StEnter;
                    win_d   = pend_win;
                end
            end

            StEnter: begin
                // The CPU instruction in this slot is squashed: its stack
                // request and ei/di are ignored.
                push          = 1'b1;
                push_data     = ret_pc;
                pc_src        = PcVec;
                pc_vec        = win_q ? vec1 : vec0;
                irq_ack[win_q] = 1'b1;

                pend_d[win_q]       = irq_rise[win_q];
                in_service_d[win_q] = 1'b1;
                gie_d               = 1'b0;
                depth_d             = depth_q + DepthOne;
                state_d             = StService;
            end

            StService: begin
                push_data = ret_pc;
                gie_d     = gie_instr;
                if (reti) begin
                    // reti owns this slot; CPU stack traffic is not forwarded
                    // so the RETURN pop cannot be doubled up.
                    if (depth_q != '0) begin
                        state_d = StReturn;
                    end else begin
                        stack_err_d = 1'b1;
                    end
                end else begin
                    push    = fwd_push;
                    pop     = fwd_pop;
                    depth_d = depth_fwd;
                    if (fwd_err) begin
                        stack_err_d = 1'b1;
                    end
                    if (preempt && (depth_fwd < DepthFull)) begin
                        state_d = StEnter;
                        win_d   = 1'b0;
                    end
                end
            end

            StReturn: begin
                pop     = 1'b1;
                pc_src  = PcStack;
                depth_d = depth_q - DepthOne;
                gie_d   = 1'b1;
                // Retire the highest-priority active handler.
                if (in_service_q[0]) begin
                    in_service_d[0] = 1'b0;
                end else begin
                    in_service_d[1] = 1'b0;
                end
                state_d = (in_service_d != 2'b00) ? StService : StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            irq_prev_q   <= 2'b00;
            pend_q       <= 2'b00;
            in_service_q <= 2'b00;
            gie_q        <= 1'b0;
            stack_err_q  <= 1'b0;
            depth_q      <= '0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq;
            pend_q       <= pend_d;
            in_service_q <= in_service_d;
            gie_q        <= gie_d;
            stack_err_q  <= stack_err_d;
            depth_q      <= depth_d;
            win_q        <= win_d;
        end
    end

    assign in_service = in_service_q;
    assign gie        = gie_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_sequencer
//
// Self-checking bench for irq_sequencer. Each cycle is one record of inputs
// plus expected outputs. The records are drawn from a table and from a few
// hand-written multi-cycle sequences. Expected records are queued when the
// stimulus is driven, then popped and compared mid-cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_irq_sequencer;

    localparam int unsigned PC_W        = 10;
    localparam int unsigned STACK_DEPTH = 8;

    localparam logic [PC_W-1:0] Vec0 = 10'h200;
    localparam logic [PC_W-1:0] Vec1 = 10'h300;

    // ctl field encoding {ei, di, reti, cpu_push, cpu_pop}
    localparam logic [4:0] CtlNone = 5'b00000;
    localparam logic [4:0] CtlEi   = 5'b10000;
    localparam logic [4:0] CtlDi   = 5'b01000;
    localparam logic [4:0] CtlReti = 5'b00100;
    localparam logic [4:0] CtlPush = 5'b00010;
    localparam logic [4:0] CtlPop  = 5'b00001;

    // care mask bits
    localparam int CPush = 0;
    localparam int CPop  = 1;
    localparam int CSrc  = 2;
    localparam int CAck  = 3;
    localparam int CIs   = 4;
    localparam int CGie  = 5;
    localparam int CErr  = 6;
    localparam logic [6:0] CareAll  = 7'h7F;
    localparam logic [6:0] CareNone = 7'h00;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] irq;
        logic [4:0] ctl;
        logic [9:0] rpc;
        logic       push;
        logic       pop;
        logic [1:0] src;
        logic [9:0] vec;
        logic [1:0] ack;
        logic [1:0] is;
        logic       gie;
        logic       err;
        logic [6:0] care;
    } vec_t;

    logic            clk;
    logic            reset;
    logic [1:0]      irq;
    logic            ei, di, reti, cpu_push, cpu_pop;
    logic [PC_W-1:0] ret_pc;
    logic [PC_W-1:0] vec0, vec1;
    logic            push, pop;
    logic [PC_W-1:0] push_data;
    logic [1:0]      pc_src;
    logic [PC_W-1:0] pc_vec;
    logic [1:0]      irq_ack;
    logic [1:0]      in_service;
    logic            gie;
    logic            stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[$];
    vec_t sb_q[$];

    irq_sequencer #(
        .PC_W       (PC_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .ei        (ei),
        .di        (di),
        .reti      (reti),
        .cpu_push  (cpu_push),
        .cpu_pop   (cpu_pop),
        .ret_pc    (ret_pc),
        .vec0      (vec0),
        .vec1      (vec1),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .pc_src    (pc_src),
        .pc_vec    (pc_vec),
        .irq_ack   (irq_ack),
        .in_service(in_service),
        .gie       (gie),
        .stack_err (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input string nm, input logic rst, input logic [1:0] i_irq,
                                input logic [4:0] ctl, input logic [9:0] rpc,
                                input logic e_push, input logic e_pop, input logic [1:0] e_src,
                                input logic [9:0] e_vec, input logic [1:0] e_ack,
                                input logic [1:0] e_is, input logic e_gie, input logic e_err,
                                input logic [6:0] care);
        vec_t v;
        v.name = nm;
        v.rst  = rst;
        v.irq  = i_irq;
        v.ctl  = ctl;
        v.rpc  = rpc;
        v.push = e_push;
        v.pop  = e_pop;
        v.src  = e_src;
        v.vec  = e_vec;
        v.ack  = e_ack;
        v.is   = e_is;
        v.gie  = e_gie;
        v.err  = e_err;
        v.care = care;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        reset    = v.rst;
        irq      = v.irq;
        ei       = v.ctl[4];
        di       = v.ctl[3];
        reti     = v.ctl[2];
        cpu_push = v.ctl[1];
        cpu_pop  = v.ctl[0];
        ret_pc   = v.rpc;
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        if (e.care[CPush]) chk(e.name, "push", 16'(push), 16'(e.push));
        if (e.care[CPush] && e.push) chk(e.name, "push_data", 16'(push_data), 16'(e.rpc));
        if (e.care[CPop])  chk(e.name, "pop", 16'(pop), 16'(e.pop));
        if (e.care[CSrc])  chk(e.name, "pc_src", 16'(pc_src), 16'(e.src));
        if (e.care[CSrc] && (e.src == 2'b01)) chk(e.name, "pc_vec", 16'(pc_vec), 16'(e.vec));
        if (e.care[CAck])  chk(e.name, "irq_ack", 16'(irq_ack), 16'(e.ack));
        if (e.care[CIs])   chk(e.name, "in_service", 16'(in_service), 16'(e.is));
        if (e.care[CGie])  chk(e.name, "gie", 16'(gie), 16'(e.gie));
        if (e.care[CErr])  chk(e.name, "stack_err", 16'(stack_err), 16'(e.err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        irq      = 2'b00;
        ei       = 1'b0;
        di       = 1'b0;
        reti     = 1'b0;
        cpu_push = 1'b0;
        cpu_pop  = 1'b0;
        ret_pc   = '0;
        vec0     = Vec0;
        vec1     = Vec1;

        // name, rst, irq, ctl, ret_pc | push, pop, src, vec, ack, is, gie, err
        tbl.push_back(mk("reset_state", 0, 2'b00, CtlNone, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 0, CareAll));
        tbl.push_back(mk("ei_irq0", 0, 2'b01, CtlEi, 10'h012,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 0, CareAll));
        tbl.push_back(mk("pend_wait", 0, 2'b00, CtlNone, 10'h012,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("enter_irq0", 0, 2'b00, CtlEi | CtlPop, 10'h012,
                         1, 0, 2'b01, Vec0, 2'b01, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("service0", 0, 2'b00, CtlNone, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b01, 0, 0, CareAll));
        tbl.push_back(mk("reti0", 0, 2'b00, CtlReti, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b01, 0, 0, CareAll));
        tbl.push_back(mk("return0", 0, 2'b00, CtlDi, 10'h000,
                         0, 1, 2'b10, 10'h0, 2'b00, 2'b01, 0, 0, CareAll));
        tbl.push_back(mk("idle_after_ret", 0, 2'b00, CtlNone, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("irq11_rise", 0, 2'b11, CtlNone, 10'h020,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("irq11_hold", 0, 2'b11, CtlNone, 10'h020,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("enter_irq0_first", 0, 2'b11, CtlNone, 10'h021,
                         1, 0, 2'b01, Vec0, 2'b01, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("reti_a", 0, 2'b00, CtlReti, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b01, 0, 0, CareAll));
        tbl.push_back(mk("return_a", 0, 2'b00, CtlNone, 10'h000,
                         0, 1, 2'b10, 10'h0, 2'b00, 2'b01, 0, 0, CareAll));
        tbl.push_back(mk("idle_pend1", 0, 2'b00, CtlNone, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("enter_irq1", 0, 2'b00, CtlNone, 10'h030,
                         1, 0, 2'b01, Vec1, 2'b10, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("reti_b", 0, 2'b00, CtlReti, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 0, 0, CareAll));
        tbl.push_back(mk("return_b", 0, 2'b00, CtlNone, 10'h000,
                         0, 1, 2'b10, 10'h0, 2'b00, 2'b10, 0, 0, CareAll));
        tbl.push_back(mk("reset_again", 1, 2'b00, CtlNone, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        tbl.push_back(mk("reti_in_idle", 0, 2'b00, CtlReti, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 0, CareAll));
        tbl.push_back(mk("err_sticky", 0, 2'b00, CtlNone, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 1, CareAll));
        tbl.push_back(mk("ei_only", 0, 2'b00, CtlEi, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 1, CareAll));
        tbl.push_back(mk("ei_di_both", 0, 2'b00, CtlEi | CtlDi, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 1, CareAll));
        tbl.push_back(mk("di_wins", 0, 2'b00, CtlNone, 10'h000,
                         0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 1, CareAll));

        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i]);

        // Overflow: fill the stack from the CPU, then an interrupt must wait.
        apply(mk("ovf_reset", 1, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 0, CareNone));
        apply(mk("ovf_ei", 0, 2'b00, CtlEi, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 0, CareAll));
        for (int i = 0; i < STACK_DEPTH; i++) begin
            apply(mk("ovf_push", 0, 2'b00, CtlPush, 10'(10'h100 + i),
                     1, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        end
        apply(mk("ovf_irq1_rise", 0, 2'b10, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        for (int i = 0; i < 3; i++) begin
            apply(mk("ovf_blocked", 0, 2'b10, CtlNone, 10'h000,
                     0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        end
        apply(mk("ovf_push9", 0, 2'b10, CtlPush, 10'h1FF,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        apply(mk("ovf_err_set", 0, 2'b10, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 1, CareAll));
        apply(mk("ovf_pop", 0, 2'b10, CtlPop, 10'h000,
                 0, 1, 2'b00, 10'h0, 2'b00, 2'b00, 1, 1, CareAll));
        apply(mk("ovf_enter", 0, 2'b10, CtlNone, 10'h0AB,
                 1, 0, 2'b01, Vec1, 2'b10, 2'b00, 1, 1, CareAll));
        apply(mk("ovf_service", 0, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 0, 1, CareAll));

        // irq[0] arrives while irq[1] is being serviced with interrupts enabled.
        apply(mk("n_reset", 1, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 0, CareNone));
        apply(mk("n_ei", 0, 2'b00, CtlEi, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 0, 0, CareAll));
        apply(mk("n_irq1", 0, 2'b10, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        apply(mk("n_pend1", 0, 2'b10, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        apply(mk("n_enter1", 0, 2'b00, CtlNone, 10'h050,
                 1, 0, 2'b01, Vec1, 2'b10, 2'b00, 1, 0, CareAll));
        apply(mk("n_ei_in_svc", 0, 2'b00, CtlEi, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 0, 0, CareAll));
        apply(mk("n_irq0", 0, 2'b01, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 1, 0, CareAll));
`ifdef NESTING_EN
        apply(mk("n_preempt_wait", 0, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 1, 0, CareAll));
        apply(mk("n_enter0", 0, 2'b00, CtlNone, 10'h060,
                 1, 0, 2'b01, Vec0, 2'b01, 2'b10, 1, 0, CareAll));
        apply(mk("n_reti1", 0, 2'b00, CtlReti, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b11, 0, 0, CareAll));
        apply(mk("n_ret1", 0, 2'b00, CtlNone, 10'h000,
                 0, 1, 2'b10, 10'h0, 2'b00, 2'b11, 0, 0, CareAll));
        apply(mk("n_reti2", 0, 2'b00, CtlReti, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 1, 0, CareAll));
        apply(mk("n_ret2", 0, 2'b00, CtlNone, 10'h000,
                 0, 1, 2'b10, 10'h0, 2'b00, 2'b10, 1, 0, CareAll));
        apply(mk("n_idle", 0, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
`else
        apply(mk("n_no_preempt", 0, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 1, 0, CareAll));
        apply(mk("n_reti", 0, 2'b00, CtlReti, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b10, 1, 0, CareAll));
        apply(mk("n_ret", 0, 2'b00, CtlNone, 10'h000,
                 0, 1, 2'b10, 10'h0, 2'b00, 2'b10, 1, 0, CareAll));
        apply(mk("n_enter0_decide", 0, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b00, 1, 0, CareAll));
        apply(mk("n_enter0", 0, 2'b00, CtlNone, 10'h061,
                 1, 0, 2'b01, Vec0, 2'b01, 2'b00, 1, 0, CareAll));
        apply(mk("n_svc0", 0, 2'b00, CtlNone, 10'h000,
                 0, 0, 2'b00, 10'h0, 2'b00, 2'b01, 0, 0, CareAll));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt controller for the single-cycle CPU.
- Latches two interrupt requests and arbitrates them by fixed priority (irq[0] highest).
- Sequences entry and exit: saves the return PC on the shared return stack, steers the PC mux to the vector or to the popped address, and tracks stack occupancy.
- Owns the stack push/pop strobes; CPU call/ret requests pass through it so the stack is never over- or under-flowed.

Parameters:
- PC_W, 10, PC / vector / stack data width.
- STACK_DEPTH, 8, return stack entries; occupancy counter range 0..STACK_DEPTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- irq  in  2  interrupt request lines, level, edge-detected internally
- ei  in  1  enable-interrupts instruction decoded this cycle
- di  in  1  disable-interrupts instruction decoded this cycle
- reti  in  1  return-from-interrupt instruction decoded this cycle
- cpu_push  in  1  CPU call wants to push
- cpu_pop  in  1  CPU ret wants to pop
- ret_pc  in  PC_W  address of next sequential instruction (PC+1)
- vec0  in  PC_W  vector for irq[0]
- vec1  in  PC_W  vector for irq[1]
- push  out  1  stack push strobe
- pop  out  1  stack pop strobe
- push_data  out  PC_W  data to stack
- pc_src  out  2  PC mux select: 00 sequential/CPU, 01 pc_vec, 10 stack output
- pc_vec  out  PC_W  selected vector
- irq_ack  out  2  one-cycle acknowledge per source
- in_service  out  2  source currently being serviced
- gie  out  1  global interrupt enable
- stack_err  out  1  sticky: overflow or underflow request refused

Behaviour:
- Reset (sync): state=IDLE, pend=0, gie=0, depth=0, stack_err=0; all strobes/outputs 0; pc_src=00.
- Edge detect: pend[i] set on cycle after irq[i] 0->1, held until acked. irq held high does not re-pend.
- States:
  - IDLE: outputs combinational from inputs; cpu_push/cpu_pop forwarded to push/pop, push_data=ret_pc.
  - ENTER: one cycle.
  - SERVICE: CPU forwarding as in IDLE.
  - RETURN: one cycle.
- IDLE->ENTER at edge when gie=1, pend!=0, depth<STACK_DEPTH. Winner = lowest set index.
  - If depth==STACK_DEPTH: stay IDLE, pend held.
- ENTER cycle:
  - push=1, push_data=ret_pc, pc_src=01, pc_vec=winner vector, irq_ack[winner]=1.
  - CPU push/pop ignored (instruction is squashed).
  - At edge: pend[winner]=0, in_service[winner]=1, gie=0, depth+1 -> SERVICE.
- SERVICE, reti=1 and depth>0 -> RETURN at edge. reti with depth==0 sets stack_err and stays.
- RETURN cycle:
  - pop=1, pc_src=10.
  - At edge: depth-1, clear highest-priority set in_service bit, gie=1.
  - Go to SERVICE if in_service still nonzero, else IDLE.
- reti in IDLE: treated as error, stack_err=1, no pop.
- CPU forwarding:
  - cpu_push with depth==STACK_DEPTH: refused, push=0, stack_err=1.
  - cpu_pop with depth==0: refused, pop=0, stack_err=1.
  - Accepted push/pop adjust depth by ±1.
  - cpu_push and cpu_pop both asserted: pop wins, stack_err=1.
- ei/di: take effect at the edge and are ignored in ENTER/RETURN. Both asserted: di wins.
- Reset mid-ENTER/RETURN: state cleared on that edge; stack contents are not owned here.

Optional Feature:
- NESTING_EN defined: in SERVICE with gie=1 (set by ei inside the handler), a pending source with index lower than the lowest active in_service bit preempts. The normal ENTER sequence runs, and in_service accumulates bits.
- Not defined: SERVICE never re-enters; pend waits until return to IDLE.

Test Plan:
- reset, ei, irq=01 pulse, ret_pc=0x012, vec0=0x200 -> ENTER 2 cycles later:
  - push=1, push_data=0x012, pc_src=01, pc_vec=0x200, irq_ack=01
  - then in_service=01, gie=0, depth=1
- In SERVICE, reti -> RETURN: pop=1, pc_src=10; next cycle in_service=00, gie=1, state IDLE, depth=0.
- irq=11 rising same cycle, gie=1 -> irq[0] acked first (vec0). After reti, irq[1] entered with vec1, irq_ack=10.
- Overflow:
  - 8 cpu_push -> depth=8, then irq[1] rises: no ENTER, pend held.
  - One cpu_pop -> ENTER follows.
  - 9th cpu_push refused -> push=0, stack_err=1.
- reti in IDLE with depth=0 -> pop=0, stack_err=1, state IDLE.
- NESTING_EN: servicing irq[1], ei, irq[0] rises -> ENTER with vec0, in_service=11, depth=2. Two retis restore in_service=10, then 00.
